axi_llc_flush_ctrl: RTL and testbench

RegBus initiator that drives the LLC configuration port to flush a selected set of ways, then reports completion. It sits between a local control source (core CSR, DMA sequencer or test harness) and the `conf_req`/`conf_resp` slave port of `axi_llc_reg_wrap`. It is the master end of that configuration interface. One flush request is written to the flush register and committed. The block then polls until the LLC clears the requested way bits.

---
 rtl/axi_llc_pkg.sv | 34 +++
 rtl/axi_llc_flush_ctrl.sv | 207 ++++++++++++++++++++
 tb/tb_axi_llc_flush_ctrl.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_llc_pkg.sv
// LLC flush controller shared definitions: register map defaults,
// flush FSM state encoding and default RegBus request/response bundles.
package axi_llc_pkg;

  localparam logic [31:0] FlushLoOffsetDflt = 32'h08;
  localparam logic [31:0] FlushHiOffsetDflt = 32'h0C;
  localparam logic [31:0] CommitOffsetDflt  = 32'h10;

  typedef enum logic [2:0] {
    IDLE,
    WR_LO,
    WR_HI,
    WR_COMMIT,
    GAP,
    RD_LO,
    RD_HI,
    CHECK
  } flush_state_e;

  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        valid;
  } axi_llc_reg_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        error;
    logic        ready;
  } axi_llc_reg_rsp_t;

endpackage

// File: rtl/axi_llc_flush_ctrl.sv
// RegBus initiator that writes a way mask to the LLC flush register,
// commits it and polls until the ways clear. AXI_LLC_FLUSH_TIMEOUT_EN adds a poll timeout.
module axi_llc_flush_ctrl
  import axi_llc_pkg::*;
#(
  parameter int unsigned SetAssociativity = 8,
  parameter logic [31:0] FlushLoOffset    = FlushLoOffsetDflt,
  parameter logic [31:0] FlushHiOffset    = FlushHiOffsetDflt,
  parameter logic [31:0] CommitOffset     = CommitOffsetDflt,
  parameter int unsigned PollGap          = 16,
  parameter int unsigned MaxPolls         = 1024,
  parameter type         reg_req_t        = axi_llc_reg_req_t,
  parameter type         reg_rsp_t        = axi_llc_reg_rsp_t
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        flush_valid_i,
  input  logic [SetAssociativity-1:0] flush_ways_i,
  output logic                        flush_ready_o,
  output logic                        busy_o,
  output logic                        done_o,
  output logic                        error_o,
  output reg_req_t                    reg_req_o,
  input  reg_rsp_t                    reg_rsp_i
);

  localparam bit HasHi = SetAssociativity > 32;
  localparam logic [15:0] GapLast = 16'(PollGap - 1);

  if (SetAssociativity == 0 || SetAssociativity > 64 ||
      PollGap == 0 || PollGap > 65535 || MaxPolls == 0) begin : g_cfg_err
    $error("axi_llc_flush_ctrl: parameter out of range");
  end

  flush_state_e state_q, state_d;
  logic [63:0]  mask_q, mask_d;
  logic [63:0]  rdata_q, rdata_d;
  logic [15:0]  gap_q, gap_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic         err_q, err_d;
  reg_req_t     req_q, req_d;
  logic         hs;

`ifdef AXI_LLC_FLUSH_TIMEOUT_EN
  localparam int unsigned PollW = $clog2(MaxPolls + 1);
  localparam logic [PollW-1:0] PollMax  = PollW'(MaxPolls);
  localparam logic [PollW-1:0] PollLast = PollW'(MaxPolls - 1);
  logic [PollW-1:0] poll_q, poll_d;
`endif

  assign hs = req_q.valid & reg_rsp_i.ready;

  // Sequence the flush: write mask, commit, then poll until clear.
  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    rdata_d = rdata_q;
    gap_d   = gap_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
`ifdef AXI_LLC_FLUSH_TIMEOUT_EN
    poll_d  = poll_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (flush_valid_i) begin
          mask_d  = 64'(flush_ways_i);
          rdata_d = '0;
`ifdef AXI_LLC_FLUSH_TIMEOUT_EN
          poll_d  = '0;
`endif
          if (flush_ways_i == '0) state_d = CHECK;
          else                    state_d = WR_LO;
        end
      end
      WR_LO: begin
        if (hs) begin
          if (HasHi) state_d = WR_HI;
          else       state_d = WR_COMMIT;
        end
      end
      WR_HI: begin
        if (hs) state_d = WR_COMMIT;
      end
      WR_COMMIT: begin
        if (hs) begin
          state_d = GAP;
          gap_d   = '0;
        end
      end
      GAP: begin
        if (gap_q == GapLast) state_d = RD_LO;
        else                  gap_d = gap_q + 16'd1;
      end
      RD_LO: begin
        if (hs) begin
          rdata_d[31:0] = reg_rsp_i.rdata;
          if (HasHi) state_d = RD_HI;
          else       state_d = CHECK;
        end
      end
      RD_HI: begin
        if (hs) begin
          rdata_d[63:32] = reg_rsp_i.rdata;
          state_d = CHECK;
        end
      end
      CHECK: begin
        if ((rdata_q & mask_q) == '0) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          state_d = GAP;
          gap_d   = '0;
`ifdef AXI_LLC_FLUSH_TIMEOUT_EN
          if (poll_q != PollMax) poll_d = poll_q + 1'b1;
          if (poll_q >= PollLast) begin
            state_d = IDLE;
            err_d   = 1'b1;
          end
`endif
        end
      end
      default: state_d = IDLE;
    endcase
    // A bus error on any completed transfer aborts the sequence.
    if (hs && reg_rsp_i.error) begin
      state_d = IDLE;
      err_d   = 1'b1;
    end
    busy_d = state_d != IDLE;
  end

  // Build the registered request for the state being entered.
  always_comb begin
    req_d = '0;
    unique case (state_d)
      WR_LO: begin
        req_d.valid = 1'b1;
        req_d.write = 1'b1;
        req_d.addr  = FlushLoOffset;
        req_d.wdata = mask_d[31:0];
        req_d.wstrb = 4'hF;
      end
      WR_HI: begin
        req_d.valid = 1'b1;
        req_d.write = 1'b1;
        req_d.addr  = FlushHiOffset;
        req_d.wdata = mask_d[63:32];
        req_d.wstrb = 4'hF;
      end
      WR_COMMIT: begin
        req_d.valid = 1'b1;
        req_d.write = 1'b1;
        req_d.addr  = CommitOffset;
        req_d.wdata = 32'h1;
        req_d.wstrb = 4'hF;
      end
      RD_LO: begin
        req_d.valid = 1'b1;
        req_d.addr  = FlushLoOffset;
      end
      RD_HI: begin
        req_d.valid = 1'b1;
        req_d.addr  = FlushHiOffset;
      end
      default: ;
    endcase
  end

  // State, datapath and output registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      mask_q  <= '0;
      rdata_q <= '0;
      gap_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      req_q   <= '0;
`ifdef AXI_LLC_FLUSH_TIMEOUT_EN
      poll_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      rdata_q <= rdata_d;
      gap_q   <= gap_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      req_q   <= req_d;
`ifdef AXI_LLC_FLUSH_TIMEOUT_EN
      poll_q  <= poll_d;
`endif
    end
  end

  assign flush_ready_o = state_q == IDLE;
  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign error_o       = err_q;
  assign reg_req_o     = req_q;

endmodule

// File: tb/tb_axi_llc_flush_ctrl.sv
// Scoreboard bench for axi_llc_flush_ctrl: an 8-way and a 64-way instance
// share one RegBus slave model; expected transfers are queued per request.
module tb_axi_llc_flush_ctrl;
  import axi_llc_pkg::*;

  localparam int PG8  = 16;
  localparam int PG64 = 3;
  localparam int MP   = 4;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
  } xfer_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic             fv;
  logic [63:0]      ways;
  logic             sel;
  axi_llc_reg_req_t req8, req64, req, hold;
  axi_llc_reg_rsp_t rsp;
  logic rdy8, rdy64, busy8, busy64;
  logic done8, done64, err8, err64;
  logic rdy, busy, done, err;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int done_cyc = 0;
  int err_cyc = 0;
  int xfer_n = 0;
  int xtra = 0;
  int rdy_mode = 0;
  logic        err_en = 1'b0;
  logic [31:0] err_addr = '0;
  logic [31:0] rd_dflt = '0;
  logic        prev_stall = 1'b0;
  logic [31:0] rd_q[$];
  xfer_t       exp_q[$];

  assign req  = sel ? req64 : req8;
  assign rdy  = sel ? rdy64 : rdy8;
  assign busy = sel ? busy64 : busy8;
  assign done = sel ? done64 : done8;
  assign err  = sel ? err64 : err8;

  axi_llc_flush_ctrl #(
    .SetAssociativity(8),
    .PollGap(PG8),
    .MaxPolls(MP)
  ) u_dut8 (
    .clk_i(clk),
    .rst_ni(rst_n),
    .flush_valid_i(fv & ~sel),
    .flush_ways_i(ways[7:0]),
    .flush_ready_o(rdy8),
    .busy_o(busy8),
    .done_o(done8),
    .error_o(err8),
    .reg_req_o(req8),
    .reg_rsp_i(rsp)
  );

  axi_llc_flush_ctrl #(
    .SetAssociativity(64),
    .PollGap(PG64),
    .MaxPolls(MP)
  ) u_dut64 (
    .clk_i(clk),
    .rst_ni(rst_n),
    .flush_valid_i(fv & sel),
    .flush_ways_i(ways),
    .flush_ready_o(rdy64),
    .busy_o(busy64),
    .done_o(done64),
    .error_o(err64),
    .reg_req_o(req64),
    .reg_rsp_i(rsp)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic exp_wr(input logic [31:0] a, input logic [31:0] d);
    exp_q.push_back('{wr: 1'b1, addr: a, data: d});
  endtask

  task automatic exp_rd(input logic [31:0] a);
    exp_q.push_back('{wr: 1'b0, addr: a, data: 32'h0});
  endtask

  function automatic int lat8(input int r);
    return 3 + r * (PG8 + 2);
  endfunction

  function automatic int lat64(input int r);
    return 4 + r * (PG64 + 3);
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // RegBus slave, stall-stability checker, transfer scoreboard, pulse monitor.
  always @(negedge clk) begin
    logic  hs;
    xfer_t e;
    if (prev_stall) begin
      chk("stable_addr", 64'(req.addr), 64'(hold.addr));
      chk("stable_ctl",
          64'({req.valid, req.write, req.wstrb, req.wdata}),
          64'({hold.valid, hold.write, hold.wstrb, hold.wdata}));
    end
    case (rdy_mode)
      0:       rsp.ready = 1'b1;
      1:       rsp.ready = $urandom_range(0, 2) != 0;
      default: rsp.ready = req.write;
    endcase
    rsp.rdata = (rd_q.size() > 0) ? rd_q[0] : rd_dflt;
    rsp.error = err_en && req.valid && (req.addr == err_addr);
    hs = req.valid && rsp.ready && rst_n;
    if (hs) begin
      xfer_n++;
      if (!req.write && rd_q.size() > 0) void'(rd_q.pop_front());
      if (exp_q.size() == 0) begin
        xtra++;
      end else begin
        e = exp_q.pop_front();
        chk("xfer_hdr", 64'({req.write, req.addr}), 64'({e.wr, e.addr}));
        if (e.wr)
          chk("xfer_data", 64'({req.wstrb, req.wdata}), 64'({4'hF, e.data}));
      end
    end
    prev_stall = req.valid && !rsp.ready && rst_n;
    hold = req;
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (err) begin
      err_cnt++;
      err_cyc = cyc;
    end
  end

  task automatic run_flush(input logic s, input logic [63:0] m,
                           input int lat, input bit want_err);
    int t, d0, e0, n, ev;
    @(negedge clk);
    sel = s;
    @(negedge clk);
    chk("ready_idle", 64'(rdy), 64'(1));
    fv = 1'b1;
    ways = m;
    t = cyc;
    d0 = done_cnt;
    e0 = err_cnt;
    @(negedge clk);
    fv = 1'b0;
    chk("busy_t1", 64'(busy), 64'(1));
    chk("valid_t1", 64'(req.valid), 64'(m != 0));
    n = 0;
    while (done_cnt == d0 && err_cnt == e0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("wait_bound", 64'(n < 3000), 64'(1));
    repeat (4) @(negedge clk);
    if (want_err) begin
      chk("err_pulses", 64'(err_cnt - e0), 64'(1));
      chk("done_pulses", 64'(done_cnt - d0), 64'(0));
      ev = err_cyc;
    end else begin
      chk("done_pulses", 64'(done_cnt - d0), 64'(1));
      chk("err_pulses", 64'(err_cnt - e0), 64'(0));
      ev = done_cyc;
    end
    if (lat >= 0) chk("latency", 64'(ev - t), 64'(lat));
    chk("ready_after", 64'(rdy), 64'(1));
    chk("busy_after", 64'(busy), 64'(0));
    chk("valid_after", 64'(req.valid), 64'(0));
    chk("xfer_left", 64'(exp_q.size()), 64'(0));
    chk("xfer_extra", 64'(xtra), 64'(0));
  endtask

  initial begin
    int n, d0, e0, x0;
    fv = 1'b0;
    ways = '0;
    sel = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_valid8", 64'(req8.valid), 64'(0));
    chk("rst_addr8", 64'(req8.addr), 64'(0));
    chk("rst_valid64", 64'(req64.valid), 64'(0));
    chk("rst_busy", 64'(busy8), 64'(0));
    chk("rst_done", 64'(done8), 64'(0));
    chk("rst_err", 64'(err8), 64'(0));
    chk("rst_ready", 64'(rdy8), 64'(1));
    rst_n = 1'b1;

    // single poll round, 8 ways
    exp_wr(32'h08, 32'hF);
    exp_wr(32'h10, 32'h1);
    exp_rd(32'h08);
    run_flush(1'b0, 64'hF, 21, 1'b0);

    // three poll rounds
    rd_q = '{32'hF, 32'h3, 32'h0};
    exp_wr(32'h08, 32'hF);
    exp_wr(32'h10, 32'h1);
    repeat (3) exp_rd(32'h08);
    run_flush(1'b0, 64'hF, lat8(3), 1'b0);

    // same under random backpressure
    rdy_mode = 1;
    x0 = xfer_n;
    rd_q = '{32'hF, 32'h3, 32'h0};
    exp_wr(32'h08, 32'hF);
    exp_wr(32'h10, 32'h1);
    repeat (3) exp_rd(32'h08);
    run_flush(1'b0, 64'hF, -1, 1'b0);
    chk("stall_xfers", 64'(xfer_n - x0), 64'(5));
    rdy_mode = 0;

    // bus error on commit
    err_en = 1'b1;
    err_addr = 32'h10;
    exp_wr(32'h08, 32'h5);
    exp_wr(32'h10, 32'h1);
    run_flush(1'b0, 64'h5, 3, 1'b1);
    err_en = 1'b0;

    // zero mask
    run_flush(1'b0, 64'h0, 2, 1'b0);

    // 64 ways, one round
    exp_wr(32'h08, 32'h1);
    exp_wr(32'h0C, 32'h8000_0000);
    exp_wr(32'h10, 32'h1);
    exp_rd(32'h08);
    exp_rd(32'h0C);
    run_flush(1'b1, 64'h8000_0000_0000_0001, lat64(1), 1'b0);

    // 64 ways, upper word pending on first round
    rd_q = '{32'h0, 32'h8000_0000, 32'h0, 32'h0};
    exp_wr(32'h08, 32'h1);
    exp_wr(32'h0C, 32'h8000_0000);
    exp_wr(32'h10, 32'h1);
    repeat (2) begin
      exp_rd(32'h08);
      exp_rd(32'h0C);
    end
    run_flush(1'b1, 64'h8000_0000_0000_0001, lat64(2), 1'b0);

`ifdef AXI_LLC_FLUSH_TIMEOUT_EN
    // readback stuck nonzero until timeout
    rd_dflt = 32'h1;
    exp_wr(32'h08, 32'h1);
    exp_wr(32'h10, 32'h1);
    repeat (MP) exp_rd(32'h08);
    run_flush(1'b0, 64'h1, lat8(MP), 1'b1);
    rd_dflt = 32'h0;
`endif

    // reset while a poll read is stalled
    @(negedge clk);
    sel = 1'b0;
    rdy_mode = 2;
    exp_wr(32'h08, 32'h1);
    exp_wr(32'h10, 32'h1);
    @(negedge clk);
    fv = 1'b1;
    ways = 64'h1;
    @(negedge clk);
    fv = 1'b0;
    n = 0;
    while (!(req8.valid && !req8.write) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("rd_pending", 64'(n < 200), 64'(1));
    d0 = done_cnt;
    e0 = err_cnt;
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_mid_valid", 64'(req8.valid), 64'(0));
    chk("rst_mid_busy", 64'(busy8), 64'(0));
    chk("rst_mid_ready", 64'(rdy8), 64'(1));
    rst_n = 1'b1;
    rdy_mode = 0;
    repeat (40) @(negedge clk);
    chk("rst_no_pulse", 64'((done_cnt - d0) + (err_cnt - e0)), 64'(0));
    chk("rst_xfer_left", 64'(exp_q.size()), 64'(0));
    chk("rst_xfer_extra", 64'(xtra), 64'(0));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
